// File: rtl/jacobi_stream_driver.sv
// jacobi_stream_driver: host-side shim that streams a stored N x N matrix into jacobi_top and captures its results
//  clk                  rising-edge clock
//  rst                  asynchronous active-low reset
//  ld_we_i/addr/dat     matrix buffer write port, honoured only while idle
//  start_i              one-cycle pulse that launches a run
//  busy_o/done_o        run in progress / one-cycle completion pulse
//  tx_dat/vld_o,rdy_i   matrix stream towards jacobi_top, row-major
//  rx_dat/vld_i,rdy_o   result stream from jacobi_top
//  rd_addr_i/rd_dat_o   result buffer read port, registered (1-cycle latency)
module jacobi_stream_driver #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int N         = 4,
  parameter int OUT_WORDS = 4,
  localparam int IN_WORDS = N * N,
  localparam int LAW      = IN_WORDS > 1 ? $clog2(IN_WORDS) : 1,
  localparam int RAW      = OUT_WORDS > 1 ? $clog2(OUT_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_we_i,
  input  logic [LAW-1:0]       ld_addr_i,
  input  logic [IN_WIDTH-1:0]  ld_dat_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IN_WIDTH-1:0]  tx_dat_o,
  output logic                 tx_vld_o,
  input  logic                 tx_rdy_i,
  input  logic [OUT_WIDTH-1:0] rx_dat_i,
  input  logic                 rx_vld_i,
  output logic                 rx_rdy_o,
  input  logic [RAW-1:0]       rd_addr_i,
  output logic [OUT_WIDTH-1:0] rd_dat_o
);
  localparam int TCW = $clog2(IN_WORDS + 1);
  localparam int RCW = $clog2(OUT_WORDS + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  localparam logic [TCW-1:0] TX_END = TCW'(IN_WORDS);
  localparam logic [RCW-1:0] RX_END = RCW'(OUT_WORDS);
  logic [1:0]           state_q, state_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [RCW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [OUT_WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic [IN_WIDTH-1:0]  in_buf [IN_WORDS];
  logic [OUT_WIDTH-1:0] out_buf [OUT_WORDS];
  logic run, launch, tx_hs, rx_hs, ld_en;
  // Stream controls derive from registered state only, so tx_vld_o never
  // depends on tx_rdy_i and drops asynchronously with reset.
  always_comb begin
    run      = state_q == RUN;
    launch   = state_q == IDLE && start_i;
    busy_o   = run;
    done_o   = state_q == FIN;
    tx_vld_o = run && tx_cnt_q < TX_END;
    rx_rdy_o = run && rx_cnt_q < RX_END;
    tx_dat_o = tx_vld_o ? in_buf[tx_cnt_q[LAW-1:0]] : '0;
    tx_hs    = tx_vld_o && tx_rdy_i;
    rx_hs    = rx_rdy_o && rx_vld_i;
    ld_en    = state_q == IDLE && ld_we_i && 32'(ld_addr_i) < IN_WORDS;
    tx_cnt_d = launch ? '0 : tx_hs ? tx_cnt_q + TCW'(1) : tx_cnt_q;
    rx_cnt_d = launch ? '0 : rx_hs ? rx_cnt_q + RCW'(1) : rx_cnt_q;
    // Completion is judged on next-cycle counts so done_o follows the final
    // handshake by exactly one cycle.
    state_d  = launch ? RUN :
               run ? (tx_cnt_d == TX_END && rx_cnt_d == RX_END ? FIN : RUN) : IDLE;
    rd_dat_d = 32'(rd_addr_i) < OUT_WORDS ? out_buf[rd_addr_i] : '0;
    rd_dat_o = rd_dat_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      rd_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      rd_dat_q <= rd_dat_d;
    end
  end
  // Buffers are plain storage and deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) in_buf[ld_addr_i] <= ld_dat_i;
    if (rx_hs) out_buf[rx_cnt_q[RAW-1:0]] <= rx_dat_i;
  end
endmodule

// File: tb/tb_jacobi_stream_driver.sv
// tb_jacobi_stream_driver: randomized self-checking bench for jacobi_stream_driver
module tb_jacobi_stream_driver;
  localparam int NN = 16;
  localparam int OW = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we_i;
  logic [3:0]  ld_addr_i;
  logic [15:0] ld_dat_i;
  logic        start_i;
  logic        busy_o, done_o;
  logic [15:0] tx_dat_o;
  logic        tx_vld_o, tx_rdy_i;
  logic [15:0] rx_dat_i;
  logic        rx_vld_i, rx_rdy_o;
  logic [1:0]  rd_addr_i;
  logic [15:0] rd_dat_o;
  logic [15:0] in_model [NN];
  logic [15:0] out_model [OW];
  int checks = 0;
  int errors = 0;
  int last_tx_cyc, fin_cyc;

  jacobi_stream_driver dut (
    .clk(clk), .rst(rst), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_dat_i(ld_dat_i),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .tx_dat_o(tx_dat_o), .tx_vld_o(tx_vld_o), .tx_rdy_i(tx_rdy_i),
    .rx_dat_i(rx_dat_i), .rx_vld_i(rx_vld_i), .rx_rdy_o(rx_rdy_o),
    .rd_addr_i(rd_addr_i), .rd_dat_o(rd_dat_o)
  );

  always #5 clk = ~clk;

  task automatic load(input bit rnd);
    for (int i = 0; i < NN; i++) begin
      in_model[i] = rnd ? 16'($urandom) : 16'(i + 1);
      @(posedge clk); #1;
      ld_we_i = 1'b1; ld_addr_i = 4'(i); ld_dat_i = in_model[i];
    end
    @(posedge clk); #1 ld_we_i = 1'b0;
  endtask

  task automatic read_back(input string tag);
    for (int a = 0; a < OW; a++) begin
      @(posedge clk); #1 rd_addr_i = 2'(a);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rd_dat_o !== out_model[a]) begin
        errors++;
        $display("FAIL %s rd addr %0d got %h exp %h", tag, a, rd_dat_o, out_model[a]);
      end
    end
  endtask

  // Drives one full run and checks every cycle against the stream rules:
  // valid/ready follow completed word counts, data follows the loaded matrix,
  // done comes the cycle after both streams have finished.
  task automatic run_stream(input int mode);
    int tx_idx, rx_idx, cyc, stall;
    bit fin, term, hs_tx, hs_rx;
    logic [3:0] exp;
    tx_idx = 0; rx_idx = 0; cyc = 0; stall = 0; fin = 0;
    last_tx_cyc = -1; fin_cyc = -1;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    while (!fin && cyc < 400) begin
      term = tx_idx == NN && rx_idx == OW;
      rx_dat_i = 16'($urandom);
      case (mode)
        0: begin tx_rdy_i = 1'b1; rx_vld_i = 1'b1; rx_dat_i = 16'(16'hA0 + rx_idx); end
        1: begin tx_rdy_i = cyc % 2 == 0; rx_vld_i = 1'($urandom); end
        2: begin
          tx_rdy_i = tx_idx < 8 || (rx_idx == OW && stall >= 3);
          rx_vld_i = tx_idx >= 8 && rx_idx < OW;
        end
        3: begin
          tx_rdy_i = 1'($urandom); rx_vld_i = 1'($urandom);
          start_i = $urandom_range(3) == 0; ld_we_i = $urandom_range(3) == 0;
          ld_addr_i = 4'($urandom); ld_dat_i = 16'($urandom);
        end
        default: begin tx_rdy_i = 1'($urandom); rx_vld_i = 1'($urandom); end
      endcase
      if (term) begin start_i = 1'b0; ld_we_i = 1'b0; end
      @(negedge clk);
      exp = term ? 4'b0100 : {1'b1, 1'b0, tx_idx < NN, rx_idx < OW};
      checks++;
      if ({busy_o, done_o, tx_vld_o, rx_rdy_o} !== exp) begin
        errors++;
        $display("FAIL ctrl mode %0d cyc %0d busy/done/vld/rdy got %b exp %b",
                 mode, cyc, {busy_o, done_o, tx_vld_o, rx_rdy_o}, exp);
      end
      if (!term && tx_idx < NN) begin
        checks++;
        if (tx_dat_o !== in_model[tx_idx]) begin
          errors++;
          $display("FAIL tx_dat mode %0d word %0d got %h exp %h", mode, tx_idx, tx_dat_o, in_model[tx_idx]);
        end
      end
      hs_tx = !term && tx_idx < NN && tx_rdy_i;
      hs_rx = !term && rx_idx < OW && rx_vld_i;
      if (hs_rx) out_model[rx_idx] = rx_dat_i;
      @(posedge clk); #1;
      if (hs_tx) begin last_tx_cyc = cyc; tx_idx++; end
      if (hs_rx) rx_idx++;
      if (mode == 2 && tx_idx == 8 && rx_idx == OW) stall++;
      if (term) begin fin = 1'b1; fin_cyc = cyc; end
      cyc++;
    end
    tx_rdy_i = 1'b0; rx_vld_i = 1'b0; start_i = 1'b0; ld_we_i = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL timeout mode %0d tx %0d rx %0d", mode, tx_idx, rx_idx);
    end
    @(negedge clk);
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++;
      $display("FAIL post_done mode %0d busy/done got %b exp 00", mode, {busy_o, done_o});
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, tx_vld_o, rx_rdy_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000", {busy_o, done_o, tx_vld_o, rx_rdy_o});
    end
    checks++;
    if (rd_dat_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_rd_dat got %h exp 0000", rd_dat_o);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_basic;
    load(1'b0);
    run_stream(0);
    checks++;
    if (last_tx_cyc !== 15 || fin_cyc !== 16) begin
      errors++;
      $display("FAIL basic_timing last_tx %0d done %0d exp 15 16", last_tx_cyc, fin_cyc);
    end
    read_back("basic");
  endtask

  task automatic test_alternating;
    load(1'b1);
    run_stream(1);
    checks++;
    if (last_tx_cyc !== 30) begin
      errors++;
      $display("FAIL alt_timing last_tx %0d exp 30", last_tx_cyc);
    end
    read_back("alt");
  endtask

  task automatic test_early_results;
    run_stream(2);
    checks++;
    if (fin_cyc !== last_tx_cyc + 1) begin
      errors++;
      $display("FAIL early_done done %0d exp %0d", fin_cyc, last_tx_cyc + 1);
    end
    read_back("early");
  endtask

  task automatic test_mid_run_pulses;
    run_stream(3);
    run_stream(4);
    read_back("pulses");
  endtask

  task automatic test_idle_rx;
    @(posedge clk); #1 rx_vld_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_dat_i = 16'($urandom);
      @(negedge clk);
      checks++;
      if (rx_rdy_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_rx_rdy cyc %0d got %b exp 0", i, rx_rdy_o);
      end
      @(posedge clk); #1;
    end
    rx_vld_i = 1'b0;
    read_back("idle_rx");
  endtask

  task automatic test_reset_mid_run;
    rd_addr_i = 2'd0;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0; tx_rdy_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (tx_vld_o !== 1'b1 || tx_dat_o !== in_model[5]) begin
      errors++;
      $display("FAIL pre_reset vld %b dat %h exp 1 %h", tx_vld_o, tx_dat_o, in_model[5]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, tx_vld_o, rx_rdy_o} !== 4'b0000 || rd_dat_o !== 16'h0) begin
      errors++;
      $display("FAIL async_reset ctrl %b rd %h exp 0000 0000", {busy_o, done_o, tx_vld_o, rx_rdy_o}, rd_dat_o);
    end
    tx_rdy_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    read_back("kept");
    run_stream(0);
    read_back("after_reset");
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      load(1'b1);
      run_stream(4);
      read_back("random");
    end
  endtask

  initial begin
    rst = 1'b0; ld_we_i = 1'b0; ld_addr_i = '0; ld_dat_i = '0; start_i = 1'b0;
    tx_rdy_i = 1'b0; rx_dat_i = '0; rx_vld_i = 1'b0; rd_addr_i = '0;
    test_reset;
    test_basic;
    test_alternating;
    test_early_results;
    test_mid_run_pulses;
    test_idle_rx;
    test_reset_mid_run;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
